// File: rtl/mmio_responder.sv
// mmio_responder: word-addressed I/O window at 0x8000_00xx.
// Serves UART status/RX/TX registers and cycle/instruction counters.
// Read data is registered (one-cycle latency) to line up with the data RAM.
module mmio_responder (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] req_addr,
    input  logic        req_re,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    input  logic        inst_retired,
    output logic        io_sel,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);
    // word offsets (req_addr[7:2])
    localparam logic [5:0] W_STATUS = 6'h00;
    localparam logic [5:0] W_RX     = 6'h01;
    localparam logic [5:0] W_TX     = 6'h02;
    localparam logic [5:0] W_CYCLE  = 6'h04;
    localparam logic [5:0] W_INSTR  = 6'h05;
    localparam logic [5:0] W_CNTRST = 6'h06;

    logic        rx_full;
    logic [7:0]  rx_byte;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
    logic [31:0] rd_mux;
    logic [5:0]  word;
    logic        acc_rd;
    logic        acc_wr;

    // byte lanes and low address bits that the map never looks at
    logic unused_bits;
    assign unused_bits = ^{req_addr[1:0], req_wdata[31:8], req_wmask[3:1]};

    assign io_sel        = (req_addr[31:8] == 24'h800000);
    assign word          = req_addr[7:2];
    assign acc_rd        = io_sel && req_re;
    assign acc_wr        = io_sel && req_we;
    assign uart_rx_ready = !rx_full;

    // read mux on pre-edge state
    always_comb begin
        rd_mux = 32'h0;
        case (word)
            W_STATUS: rd_mux = {30'h0, rx_full, !uart_tx_valid};
            W_RX:     rd_mux = rx_full ? {24'h0, rx_byte} : 32'h0;
            W_CYCLE:  rd_mux = cycle_cnt;
            W_INSTR:  rd_mux = instr_cnt;
            default:  rd_mux = 32'h0;
        endcase
    end

    // registered load data and one-cycle valid pulse
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= acc_rd;
            if (acc_rd)
                rdata <= rd_mux;
        end
    end

    // RX holding register: pop on read, capture only when empty
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_full <= 1'b0;
            rx_byte <= 8'h0;
        end else if (rx_full) begin
            if (acc_rd && word == W_RX)
                rx_full <= 1'b0;
        end else if (uart_rx_valid) begin
            rx_full <= 1'b1;
            rx_byte <= uart_rx_data;
        end
    end

    // TX holding register: writes only land when it was empty before the edge
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h0;
        end else if (uart_tx_valid) begin
            if (uart_tx_ready)
                uart_tx_valid <= 1'b0;
        end else if (acc_wr && word == W_TX && req_wmask[0]) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= req_wdata[7:0];
        end
    end

    // free-running counters; a CNT_RESET write wins over that cycle's increment
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt <= 32'h0;
            instr_cnt <= 32'h0;
        end else if (acc_wr && word == W_CNTRST) begin
            cycle_cnt <= 32'h0;
            instr_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            instr_cnt <= instr_cnt + {31'h0, inst_retired};
        end
    end
endmodule
